// File: rtl/exp_sub_if.sv
// rtl/exp_sub_if.sv - exponent-difference stage request/result bundle
interface exp_sub_if #(
    parameter int EW = 11
);
    logic          in_valid;
    logic [EW-1:0] ea;
    logic [EW-1:0] eb;
    logic          out_valid;
    logic          eb_gt_ea;
    logic [EW-1:0] as;

    modport master (
        output in_valid, ea, eb,
        input  out_valid, eb_gt_ea, as
    );

    modport slave (
        input  in_valid, ea, eb,
        output out_valid, eb_gt_ea, as
    );
endinterface

// File: rtl/exp_sub.sv
// rtl/exp_sub.sv - FP adder exponent difference, one-stage pipeline
// Optional shift saturation at CLAMP enabled by defining EXP_SUB_CLAMP_EN.
module exp_sub #(
    parameter int EW    = 11,
    parameter int CLAMP = 55
) (
    input  logic      clk,
    input  logic      rst_n,
    exp_sub_if.slave  bus
);
    logic [EW:0]   diff;
    logic [EW-1:0] mag;
    logic          eb_gt_ea_d;
    logic [EW-1:0] as_d;
    logic          out_valid_q;
    logic          eb_gt_ea_q;
    logic [EW-1:0] as_q;

    always_comb begin
        diff       = {1'b0, bus.ea} - {1'b0, bus.eb};
        eb_gt_ea_d = diff[EW];
        // Subtract smaller from larger so the magnitude never wraps.
        mag        = eb_gt_ea_d ? (bus.eb - bus.ea) : (bus.ea - bus.eb);
`ifdef EXP_SUB_CLAMP_EN
        as_d       = (mag > EW'(CLAMP)) ? EW'(CLAMP) : mag;
`else
        as_d       = mag;
`endif
    end

`ifndef EXP_SUB_CLAMP_EN
    logic [EW-1:0] unused_clamp;
    assign unused_clamp = EW'(CLAMP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            eb_gt_ea_q  <= 1'b0;
            as_q        <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                eb_gt_ea_q <= eb_gt_ea_d;
                as_q       <= as_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.eb_gt_ea  = eb_gt_ea_q;
    assign bus.as        = as_q;
endmodule

// File: tb/tb_exp_sub.sv
// tb/tb_exp_sub.sv - randomized self-checking bench for exp_sub
module tb_exp_sub;
    localparam int EW    = 11;
    localparam int CLAMP = 55;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    int   exp_valid;
    int   exp_gt;
    int   exp_as;

    exp_sub_if #(.EW(EW)) bus ();

    exp_sub #(.EW(EW), .CLAMP(CLAMP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_as(input int a, input int b);
        int m;
        m = (a > b) ? a - b : b - a;
`ifdef EXP_SUB_CLAMP_EN
        if (m > CLAMP) m = CLAMP;
`endif
        return m;
    endfunction

    task automatic check_out(input string tag);
        check({tag, ".valid"}, int'(bus.out_valid), exp_valid);
        check({tag, ".gt"},    int'(bus.eb_gt_ea),  exp_gt);
        check({tag, ".as"},    int'(bus.as),        exp_as);
    endtask

    // Check the previous cycle's result, then present the next operand pair.
    task automatic step(input string tag, input bit v, input int a, input int b);
        @(negedge clk);
        check_out(tag);
        bus.in_valid = v;
        bus.ea       = a[EW-1:0];
        bus.eb       = b[EW-1:0];
        if (v) begin
            exp_valid = 1;
            exp_gt    = (b > a) ? 1 : 0;
            exp_as    = ref_as(a, b);
        end else begin
            exp_valid = 0;
        end
    endtask

    initial begin
        int a;
        int b;
        checks      = 0;
        errors      = 0;
        exp_valid   = 0;
        exp_gt      = 0;
        exp_as      = 0;
        rst_n       = 1'b0;
        bus.in_valid = 1'b0;
        bus.ea       = '0;
        bus.eb       = '0;

        @(negedge clk);
        check_out("reset");
        rst_n = 1'b1;

        step("idle",    0, 0, 0);
        step("d_1_0",   1, 1, 0);
        step("d_eq1",   1, 1, 1);
        step("d_eq124", 1, 'h124, 'h124);
        step("d_400",   1, 'h400, 'h200);
        step("d_2aa",   1, 'h2AA, 'h555);
        step("d_7ff_0", 1, 'h7FF, 'h000);
        step("d_7ff_4", 1, 'h7FF, 'h400);
        step("d_0_7ff", 1, 'h000, 'h7FF);
        step("d_hold",  0, 'h123, 'h456);
        step("d_hold2", 0, 'h001, 'h002);

        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 2047));
            case ($urandom_range(0, 4))
                0:       b = a;
                1:       b = int'($urandom_range(0, 2047)) & 'h03F;
                default: b = int'($urandom_range(0, 2047));
            endcase
            step("rand", ($urandom_range(0, 3) != 0), a, b);
        end

        step("pre_rst", 1, 'h7FF, 'h000);
        @(negedge clk);
        check_out("pre_rst_out");
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_valid = 0;
        exp_gt    = 0;
        exp_as    = 0;
        check_out("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, 0, 0);
        step("post_rst2", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
